pcie4_cfg_mgmt_arbiter: RTL and testbench



---
 rtl/pcie4_cfg_mgmt_arb_pkg.sv | 10 +
 rtl/pcie4_cfg_mgmt_arbiter_rr_arbiter.sv | 27 ++
 rtl/pcie4_cfg_mgmt_arbiter.sv | 179 +++++++++++++++++
 tb/tb_pcie4_cfg_mgmt_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie4_cfg_mgmt_arb_pkg.sv
// pcie4_cfg_mgmt_arb_pkg: shared state encoding and width helpers for the cfg_mgmt arbiter
package pcie4_cfg_mgmt_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE, GAP} arb_state_t;
  localparam int ARB_DEF_DATA_WIDTH = 32;
  localparam int ARB_DEF_BE_WIDTH = ARB_DEF_DATA_WIDTH / 8;
  localparam logic [ARB_DEF_DATA_WIDTH-1:0] ARB_ERR_DATA = '1;
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/pcie4_cfg_mgmt_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  logic [IW-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pcie4_cfg_mgmt_arbiter.sv
// pcie4_cfg_mgmt_arbiter: round-robin sharing of one cfg_mgmt master among C_NUM_REQ requesters.
// Define PCIE4_CFG_MGMT_ARB_TIMEOUT_EN to add a completion timeout of C_TIMEOUT_CYCLES.
module pcie4_cfg_mgmt_arbiter
  import pcie4_cfg_mgmt_arb_pkg::*;
#(
  parameter int C_NUM_REQ = 2,
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_FUNCTION_NUMBER_WIDTH = 8,
  parameter int C_TIMEOUT_CYCLES = 1024
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0]        s_addr,
  input  logic [C_NUM_REQ-1:0]                     s_write_en,
  input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0]        s_write_data,
  input  logic [C_NUM_REQ*(C_DATA_WIDTH/8)-1:0]    s_byte_en,
  input  logic [C_NUM_REQ-1:0]                     s_read_en,
  input  logic [C_NUM_REQ*C_FUNCTION_NUMBER_WIDTH-1:0] s_function_number,
  input  logic [C_NUM_REQ-1:0]                     s_debug_access,
  output logic [C_DATA_WIDTH-1:0]                  s_read_data,
  output logic [C_NUM_REQ-1:0]                     s_read_write_done,
  output logic [C_NUM_REQ-1:0]                     s_error,
  output logic [C_ADDR_WIDTH-1:0]                  m_addr,
  output logic                                     m_write_en,
  output logic [C_DATA_WIDTH-1:0]                  m_write_data,
  output logic [C_DATA_WIDTH/8-1:0]                m_byte_en,
  output logic                                     m_read_en,
  output logic [C_FUNCTION_NUMBER_WIDTH-1:0]       m_function_number,
  output logic                                     m_debug_access,
  input  logic [C_DATA_WIDTH-1:0]                  m_read_data,
  input  logic                                     m_read_write_done,
  output logic [C_NUM_REQ-1:0]                     grant
);
  localparam int N = C_NUM_REQ;
  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;
  localparam int FW = C_FUNCTION_NUMBER_WIDTH;
  localparam int BW = be_width(C_DATA_WIDTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  if (C_NUM_REQ < 1 || C_NUM_REQ > 8 || C_TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("pcie4_cfg_mgmt_arbiter: parameter out of range");
  end
  arb_state_t state_q, state_d;
  logic [N-1:0] req, win, grant_q, grant_d, done_q, done_d;
  logic [IW-1:0] win_idx, own_q, own_d, last_q, last_d;
  logic win_any;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BW-1:0] be_q, be_d;
  logic [FW-1:0] fn_q, fn_d;
  logic we_q, we_d, re_q, re_d, dbg_q, dbg_d;
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] err_q, err_d;
  assign s_error = err_q;
`else
  assign s_error = '0;
`endif
  assign req = s_write_en | s_read_en;
  rr_arbiter #(.N(N)) u_rr (
    .req(req),
    .last(last_q),
    .gnt(win),
    .gnt_idx(win_idx),
    .any(win_any)
  );
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d = own_q;
    last_d = last_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    fn_d = fn_q;
    dbg_d = dbg_q;
    we_d = we_q;
    re_d = re_q;
    rdata_d = '0;
    done_d = '0;
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
    err_d = '0;
    cnt_d = cnt_q + 1'b1;
`endif
    unique case (state_q)
      IDLE: if (win_any) begin
        state_d = ISSUE;
        grant_d = win;
        own_d = win_idx;
        addr_d = s_addr[int'(win_idx)*AW +: AW];
        wdata_d = s_write_data[int'(win_idx)*DW +: DW];
        be_d = s_byte_en[int'(win_idx)*BW +: BW];
        fn_d = s_function_number[int'(win_idx)*FW +: FW];
        dbg_d = s_debug_access[win_idx];
        we_d = s_write_en[win_idx];
        re_d = s_read_en[win_idx] & ~s_write_en[win_idx];
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ISSUE: if (m_read_write_done) begin
        state_d = DONE;
        we_d = 1'b0;
        re_d = 1'b0;
        rdata_d = re_q ? m_read_data : '0;
        done_d = grant_q;
      end
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(C_TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        we_d = 1'b0;
        re_d = 1'b0;
        rdata_d = '1;
        done_d = grant_q;
        err_d = grant_q;
      end
`endif
      DONE: begin
        last_d = own_q;
        state_d = GAP;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q <= '0;
      last_q <= IW'(N - 1);
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      fn_q <= '0;
      dbg_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      rdata_q <= '0;
      done_q <= '0;
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
      err_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q <= own_d;
      last_q <= last_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      fn_q <= fn_d;
      dbg_q <= dbg_d;
      we_q <= we_d;
      re_q <= re_d;
      rdata_q <= rdata_d;
      done_q <= done_d;
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
      err_q <= err_d;
      cnt_q <= cnt_d;
`endif
    end
  end
  assign s_read_data = rdata_q;
  assign s_read_write_done = done_q;
  assign grant = grant_q;
  assign m_addr = addr_q;
  assign m_write_en = we_q;
  assign m_read_en = re_q;
  assign m_write_data = wdata_q;
  assign m_byte_en = be_q;
  assign m_function_number = fn_q;
  assign m_debug_access = dbg_q;
endmodule

// File: tb/tb_pcie4_cfg_mgmt_arbiter.sv
// tb_pcie4_cfg_mgmt_arbiter: directed scoreboard bench with a latency-programmable master model
module tb_pcie4_cfg_mgmt_arbiter;
  localparam int N = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FW = 8;
  localparam int BW = 4;
  localparam int TO = 16;
  typedef struct {
    logic [N-1:0] g;
    logic we;
    logic re;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    logic [FW-1:0] fn;
    logic dbg;
    int len;
  } iss_t;
  typedef struct {
    logic [N-1:0] d;
    logic [DW-1:0] rd;
    logic [N-1:0] e;
  } cmp_t;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;
  logic [AW-1:0] ra[N];
  logic [DW-1:0] rwd[N];
  logic [BW-1:0] rbe[N];
  logic [FW-1:0] rfn[N];
  logic [N-1:0] s_write_en, s_read_en, s_debug_access;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_write_data;
  logic [N*BW-1:0] s_byte_en;
  logic [N*FW-1:0] s_function_number;
  logic [DW-1:0] s_read_data, m_write_data, m_read_data, mdata;
  logic [N-1:0] s_read_write_done, s_error, grant;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_byte_en;
  logic [FW-1:0] m_function_number;
  logic m_write_en, m_read_en, m_debug_access, m_read_write_done;
  logic resp_done, stray;
  int mlat, ecnt, elen;
  logic prev_en;
  int rem[N], sent[N];
  int tests = 0, fails = 0;
  iss_t iq[$];
  cmp_t cq[$];
  iss_t cur;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_addr[i*AW +: AW] = ra[i];
      s_write_data[i*DW +: DW] = rwd[i];
      s_byte_en[i*BW +: BW] = rbe[i];
      s_function_number[i*FW +: FW] = rfn[i];
    end
  end
  assign m_read_write_done = resp_done | stray;
  pcie4_cfg_mgmt_arbiter #(
    .C_NUM_REQ(N),
    .C_ADDR_WIDTH(AW),
    .C_DATA_WIDTH(DW),
    .C_FUNCTION_NUMBER_WIDTH(FW),
    .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_addr(s_addr),
    .s_write_en(s_write_en),
    .s_write_data(s_write_data),
    .s_byte_en(s_byte_en),
    .s_read_en(s_read_en),
    .s_function_number(s_function_number),
    .s_debug_access(s_debug_access),
    .s_read_data(s_read_data),
    .s_read_write_done(s_read_write_done),
    .s_error(s_error),
    .m_addr(m_addr),
    .m_write_en(m_write_en),
    .m_write_data(m_write_data),
    .m_byte_en(m_byte_en),
    .m_read_en(m_read_en),
    .m_function_number(m_function_number),
    .m_debug_access(m_debug_access),
    .m_read_data(m_read_data),
    .m_read_write_done(m_read_write_done),
    .grant(grant)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] fwd(input int r, input int k);
    return 32'hC0DE_0000 | DW'(r << 12) | DW'(k);
  endfunction
  function automatic logic [BW-1:0] fbe(input int r, input int k);
    return BW'((k * 3 + r * 5 + 1) % 16);
  endfunction
  task automatic raise(input int r, input logic we, input logic re, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be, input logic [FW-1:0] fn,
                       input logic dbg, input int n);
    ra[r] = a;
    rwd[r] = wd;
    rbe[r] = be;
    rfn[r] = fn;
    s_debug_access[r] = dbg;
    rem[r] = n;
    sent[r] = 0;
    s_write_en[r] = we;
    s_read_en[r] = re;
  endtask
  task automatic push_iss(input logic [N-1:0] g, input logic we, input logic re, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be, input logic [FW-1:0] fn,
                          input logic dbg, input int len);
    iss_t t;
    t.g = g; t.we = we; t.re = re; t.a = a; t.wd = wd; t.be = be; t.fn = fn; t.dbg = dbg; t.len = len;
    iq.push_back(t);
  endtask
  task automatic push_cmp(input logic [N-1:0] d, input logic [DW-1:0] rd, input logic [N-1:0] e);
    cmp_t c;
    c.d = d; c.rd = rd; c.e = e;
    cq.push_back(c);
  endtask
  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (iq.size() != 0 || cq.size() != 0 || s_write_en != 0 || s_read_en != 0); i++)
      @(negedge aclk);
    check(tag, 64'(iq.size() == 0 && cq.size() == 0 && s_write_en == 0 && s_read_en == 0), 64'(1));
    repeat (2) @(negedge aclk);
  endtask
  always @(negedge aclk) begin
    logic en;
    cmp_t c;
    en = m_write_en | m_read_en;
    if (en) begin
      ecnt++;
      resp_done = (mlat != 0 && ecnt == mlat);
    end else begin
      ecnt = 0;
      resp_done = 1'b0;
    end
    m_read_data = mdata;
    if (en && !prev_en) begin
      elen = 0;
      if (iq.size() == 0) check("unexpected_issue", 64'(1), 64'(0));
      else begin
        cur = iq.pop_front();
        check("iss_grant", 64'(grant), 64'(cur.g));
        check("iss_we", 64'(m_write_en), 64'(cur.we));
        check("iss_re", 64'(m_read_en), 64'(cur.re));
        check("iss_addr", 64'(m_addr), 64'(cur.a));
        check("iss_wdata", 64'(m_write_data), 64'(cur.wd));
        check("iss_be", 64'(m_byte_en), 64'(cur.be));
        check("iss_fn", 64'(m_function_number), 64'(cur.fn));
        check("iss_dbg", 64'(m_debug_access), 64'(cur.dbg));
      end
    end
    if (en) elen++;
    if (!en && prev_en && cur.len != 0) check("en_len", 64'(elen), 64'(cur.len));
    prev_en = en;
    if (s_error != 0 && s_read_write_done == 0) check("err_without_done", 64'(s_error), 64'(0));
    if (s_read_write_done != 0) begin
      if (cq.size() == 0) check("unexpected_done", 64'(s_read_write_done), 64'(0));
      else begin
        c = cq.pop_front();
        check("done_vec", 64'(s_read_write_done), 64'(c.d));
        check("rdata", 64'(s_read_data), 64'(c.rd));
        check("error", 64'(s_error), 64'(c.e));
      end
      for (int r = 0; r < N; r++) begin
        if (s_read_write_done[r]) begin
          sent[r]++;
          if (sent[r] < rem[r]) begin
            rwd[r] = fwd(r, sent[r]);
            rbe[r] = fbe(r, sent[r]);
          end else begin
            s_write_en[r] = 1'b0;
            s_read_en[r] = 1'b0;
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int r = 0; r < N; r++) begin
      ra[r] = '0; rwd[r] = '0; rbe[r] = '0; rfn[r] = '0; rem[r] = 0; sent[r] = 0;
    end
    s_write_en = '0; s_read_en = '0; s_debug_access = '0;
    stray = 1'b0; resp_done = 1'b0; mlat = 1; mdata = '0; ecnt = 0; elen = 0; prev_en = 1'b0;
    cur.len = 0;
    repeat (3) @(negedge aclk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_m_en", 64'({m_write_en, m_read_en}), 64'(0));
    check("rst_done", 64'(s_read_write_done), 64'(0));
    check("rst_rdata", 64'(s_read_data), 64'(0));
    check("rst_err", 64'(s_error), 64'(0));
    check("rst_addr", 64'(m_addr), 64'(0));
    areset = 1'b0;
    @(negedge aclk);
    mlat = 3; mdata = 32'hDEADBEEF;
    push_iss(2'b01, 1'b0, 1'b1, 10'h010, 32'h1111_1111, 4'hF, 8'h03, 1'b1, 3);
    push_cmp(2'b01, 32'hDEADBEEF, 2'b00);
    raise(0, 1'b0, 1'b1, 10'h010, 32'h1111_1111, 4'hF, 8'h03, 1'b1, 1);
    drain("t1_single_read", 50);
    mlat = 2; mdata = 32'hA5A5A5A5;
    push_iss(2'b10, 1'b1, 1'b0, 10'h155, 32'h12345678, 4'hC, 8'h21, 1'b0, 2);
    push_cmp(2'b10, 32'h0, 2'b00);
    raise(1, 1'b1, 1'b1, 10'h155, 32'h12345678, 4'hC, 8'h21, 1'b0, 1);
    drain("t2_read_write", 50);
    mlat = 1; mdata = 32'hFFFF0000;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < N; r++) begin
        push_iss(N'(1 << r), 1'b1, 1'b0, AW'(10'h200 + r), fwd(r, k), fbe(r, k), FW'(8'h40 + r), r[0], 1);
        push_cmp(N'(1 << r), 32'h0, 2'b00);
      end
    end
    for (int r = 0; r < N; r++)
      raise(r, 1'b1, 1'b0, AW'(10'h200 + r), fwd(r, 0), fbe(r, 0), FW'(8'h40 + r), r[0], 3);
    drain("t3_alternate", 200);
    stray = 1'b1;
    @(negedge aclk);
    stray = 1'b0;
    check("stray_idle_done", 64'(s_read_write_done), 64'(0));
    check("stray_idle_grant", 64'(grant), 64'(0));
    @(negedge aclk);
    check("stray_idle_done2", 64'(s_read_write_done), 64'(0));
    check("stray_idle_m_en", 64'({m_write_en, m_read_en}), 64'(0));
    mlat = 1; mdata = 32'h0;
    push_iss(2'b01, 1'b1, 1'b0, 10'h3FF, 32'h0BADCAFE, 4'h5, 8'h07, 1'b0, 1);
    push_cmp(2'b01, 32'h0, 2'b00);
    raise(0, 1'b1, 1'b0, 10'h3FF, 32'h0BADCAFE, 4'h5, 8'h07, 1'b0, 1);
    for (int i = 0; i < 50 && !s_read_write_done[0]; i++) @(negedge aclk);
    check("t4_done_seen", 64'(s_read_write_done[0]), 64'(1));
    stray = 1'b1;
    @(negedge aclk);
    check("stray_gap_done", 64'(s_read_write_done), 64'(0));
    @(negedge aclk);
    stray = 1'b0;
    check("stray_gap_done2", 64'(s_read_write_done), 64'(0));
    check("stray_gap_grant", 64'(grant), 64'(0));
    @(negedge aclk);
    check("stray_gap_done3", 64'(s_read_write_done), 64'(0));
    check("stray_gap_m_en", 64'({m_write_en, m_read_en}), 64'(0));
`ifdef PCIE4_CFG_MGMT_ARB_TIMEOUT_EN
    mlat = 0; mdata = 32'h1234_0000;
    push_iss(2'b10, 1'b0, 1'b1, 10'h0AA, 32'h0, 4'h1, 8'h09, 1'b1, TO);
    push_cmp(2'b10, 32'hFFFFFFFF, 2'b10);
    raise(1, 1'b0, 1'b1, 10'h0AA, 32'h0, 4'h1, 8'h09, 1'b1, 1);
    drain("t5_timeout", 100);
    mlat = 2; mdata = 32'h600DF00D;
    push_iss(2'b01, 1'b0, 1'b1, 10'h0AB, 32'h0, 4'h2, 8'h0A, 1'b0, 2);
    push_cmp(2'b01, 32'h600DF00D, 2'b00);
    raise(0, 1'b0, 1'b1, 10'h0AB, 32'h0, 4'h2, 8'h0A, 1'b0, 1);
    drain("t5_after_timeout", 50);
`endif
    mlat = 0; mdata = 32'h0;
    push_iss(2'b10, 1'b0, 1'b1, 10'h111, 32'h0, 4'h3, 8'h11, 1'b0, 0);
    raise(1, 1'b0, 1'b1, 10'h111, 32'h0, 4'h3, 8'h11, 1'b0, 1);
    for (int i = 0; i < 20 && !m_read_en; i++) @(negedge aclk);
    check("t6_issue_seen", 64'(m_read_en), 64'(1));
    repeat (3) @(negedge aclk);
    areset = 1'b1;
    s_read_en[1] = 1'b0;
    @(negedge aclk);
    check("t6_rst_grant", 64'(grant), 64'(0));
    check("t6_rst_m_en", 64'({m_write_en, m_read_en}), 64'(0));
    check("t6_rst_done", 64'(s_read_write_done), 64'(0));
    check("t6_rst_rdata", 64'(s_read_data), 64'(0));
    areset = 1'b0;
    stray = 1'b1;
    @(negedge aclk);
    stray = 1'b0;
    @(negedge aclk);
    check("t6_late_done", 64'(s_read_write_done), 64'(0));
    check("t6_late_grant", 64'(grant), 64'(0));
    check("t6_queue_empty", 64'(iq.size() + cq.size()), 64'(0));
    mlat = 1; mdata = 32'h5EED_0001;
    push_iss(2'b01, 1'b0, 1'b1, 10'h021, 32'h0, 4'h4, 8'h01, 1'b0, 1);
    push_cmp(2'b01, 32'h5EED_0001, 2'b00);
    push_iss(2'b10, 1'b0, 1'b1, 10'h022, 32'h0, 4'h8, 8'h02, 1'b1, 1);
    push_cmp(2'b10, 32'h5EED_0001, 2'b00);
    raise(0, 1'b0, 1'b1, 10'h021, 32'h0, 4'h4, 8'h01, 1'b0, 1);
    raise(1, 1'b0, 1'b1, 10'h022, 32'h0, 4'h8, 8'h02, 1'b1, 1);
    drain("t6_after_reset", 50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
